// File: rtl/fp_mul_pipe.sv
// Pipelined parametrised FP multiplier: unpack, multiply, round/pack.
// Denormals flush to zero; round-to-nearest-even; per-result flags.
module fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int W     = EXP_W + MAN_W + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] c,
  output logic [3:0]   flags
);

  localparam int P  = 2 * MAN_W + 2;
  localparam int EW = EXP_W + 2;
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [EW-1:0] BIAS =
    EW'((1 << (EXP_W - 1)) - 1);
  localparam logic [W-1:0] QNAN =
    {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

  logic stall;
  logic take;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign take     = in_valid & in_ready;

  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic a_zero, a_inf, a_nan, a_snan;
  logic b_zero, b_inf, b_nan, b_snan;
  logic sgn;
  logic [EW-1:0] e_sum;

  assign ea = a[W-2 -: EXP_W];
  assign eb = b[W-2 -: EXP_W];
  assign fa = a[MAN_W-1:0];
  assign fb = b[MAN_W-1:0];

  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == EMAX) & (fa == '0);
  assign b_inf  = (eb == EMAX) & (fb == '0);
  assign a_nan  = (ea == EMAX) & (fa != '0);
  assign b_nan  = (eb == EMAX) & (fb != '0);
  assign a_snan = a_nan & ~fa[MAN_W-1];
  assign b_snan = b_nan & ~fb[MAN_W-1];

  assign sgn   = a[W-1] ^ b[W-1];
  assign e_sum = EW'({2'b00, ea}) + EW'({2'b00, eb}) - BIAS;

  logic         sp_en;
  logic [W-1:0] sp_val;
  logic [3:0]   sp_flg;

  // Specials resolved up front; the arithmetic path is ignored for them.
  always_comb begin
    sp_en  = 1'b1;
    sp_val = QNAN;
    sp_flg = 4'b0000;
    if (a_nan | b_nan) begin
      sp_flg = {a_snan | b_snan, 3'b000};
    end else if ((a_zero & b_inf) | (a_inf & b_zero)) begin
      sp_flg = 4'b1000;
    end else if (a_inf | b_inf) begin
      sp_val = {sgn, EMAX, {MAN_W{1'b0}}};
    end else if (a_zero | b_zero) begin
      sp_val = {sgn, {(W-1){1'b0}}};
    end else begin
      sp_en = 1'b0;
    end
  end

  logic           v1, v2;
  logic           s1_sign, s2_sign;
  logic [EW-1:0]  s1_exp, s2_exp;
  logic [MAN_W:0] s1_ma, s1_mb;
  logic [P-1:0]   s2_prod;
  logic           s1_sp, s2_sp;
  logic [W-1:0]   s1_spv, s2_spv;
  logic [3:0]     s1_spf, s2_spf;

  logic [P-2:0]   nrm;
  logic [MAN_W-1:0] frac;
  logic           grd, stk, rup, inex;
  logic [MAN_W:0] rsum;
  logic [EW-1:0]  e1;
  logic           ovf, unf;
  logic [W-1:0]   res;
  logic [3:0]     flg;

  assign nrm = s2_prod[P-1] ? s2_prod[P-2:0]
                            : {s2_prod[P-3:0], 1'b0};
  assign frac = nrm[P-2 -: MAN_W];
  assign grd  = nrm[MAN_W];
  assign stk  = |nrm[MAN_W-1:0];
  assign rup  = grd & (stk | frac[0]);
  assign inex = grd | stk;
  assign rsum = {1'b0, frac} + (MAN_W+1)'(rup);
  // Rounding carry leaves rsum[MAN_W-1:0] at zero: 1.0 at exp+1.
  assign e1 = s2_exp + EW'(s2_prod[P-1]) + EW'(rsum[MAN_W]);
  assign ovf = $signed(e1) >= $signed({2'b00, EMAX});
  assign unf = $signed(e1) < $signed(EW'(1));

  always_comb begin
    res = {s2_sign, e1[EXP_W-1:0], rsum[MAN_W-1:0]};
    flg = {3'b000, inex};
    if (s2_sp) begin
      res = s2_spv;
      flg = s2_spf;
    end else if (ovf) begin
      res = {s2_sign, EMAX, {MAN_W{1'b0}}};
      flg = 4'b0101;
    end else if (unf) begin
      res = {s2_sign, {(W-1){1'b0}}};
      flg = 4'b0011;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      s1_sign   <= 1'b0;
      s1_exp    <= '0;
      s1_ma     <= '0;
      s1_mb     <= '0;
      s1_sp     <= 1'b0;
      s1_spv    <= '0;
      s1_spf    <= '0;
      s2_sign   <= 1'b0;
      s2_exp    <= '0;
      s2_prod   <= '0;
      s2_sp     <= 1'b0;
      s2_spv    <= '0;
      s2_spf    <= '0;
      c         <= '0;
      flags     <= '0;
    end else if (!stall) begin
      v1        <= take;
      v2        <= v1;
      out_valid <= v2;
      if (take) begin
        s1_sign <= sgn;
        s1_exp  <= e_sum;
        s1_ma   <= {1'b1, fa};
        s1_mb   <= {1'b1, fb};
        s1_sp   <= sp_en;
        s1_spv  <= sp_val;
        s1_spf  <= sp_flg;
      end
      if (v1) begin
        s2_sign <= s1_sign;
        s2_exp  <= s1_exp;
        s2_prod <= P'(s1_ma) * P'(s1_mb);
        s2_sp   <= s1_sp;
        s2_spv  <= s1_spv;
        s2_spf  <= s1_spf;
      end
      if (v2) begin
        c     <= res;
        flags <= flg;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed bench: single- and half-precision instances of fp_mul_pipe.
// Vector tables plus latency, streaming, backpressure and reset sequences.
module tb_fp_mul_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        iv, ir, ov, ordy;
  logic [31:0] a, b, c;
  logic [3:0]  fl;

  logic        hiv, hir, hov, hordy;
  logic [15:0] ha, hb, hc;
  logic [3:0]  hfl;

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut_sp (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv), .in_ready(ir),
    .a(a), .b(b),
    .out_valid(ov), .out_ready(ordy),
    .c(c), .flags(fl)
  );

  fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) dut_hp (
    .clk(clk), .rst_n(rst_n),
    .in_valid(hiv), .in_ready(hir),
    .a(ha), .b(hb),
    .out_valid(hov), .out_ready(hordy),
    .c(hc), .flags(hfl)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [3:0]  f;
  } vec_t;

  task automatic run_sp(input vec_t v, input string nm);
    int lat;
    a  = v.a;
    b  = v.b;
    iv = 1'b1;
    chk({nm, " in_ready"}, 32'(ir), 32'd1);
    @(posedge clk); #1;
    iv  = 1'b0;
    lat = 1;
    while (!ov && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, " latency"}, 32'(lat), 32'd3);
    chk({nm, " c"}, c, v.c);
    chk({nm, " flags"}, 32'(fl), 32'(v.f));
  endtask

  task automatic run_hp(input vec_t v, input string nm);
    int lat;
    ha  = v.a[15:0];
    hb  = v.b[15:0];
    hiv = 1'b1;
    @(posedge clk); #1;
    hiv = 1'b0;
    lat = 1;
    while (!hov && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, " latency"}, 32'(lat), 32'd3);
    chk({nm, " c"}, 32'(hc), v.c);
    chk({nm, " flags"}, 32'(hfl), 32'(v.f));
  endtask

  vec_t sv[14];
  vec_t hv[7];
  logic [31:0] pa[4], pb[4], pc[4];

  initial begin
    int acc;
    logic ok;
    logic seen;

    sv[0]  = '{32'h40000000, 32'h447A0000, 32'h44FA0000, 4'b0000};
    sv[1]  = '{32'h41200000, 32'hC2C60000, 32'hC4778000, 4'b0000};
    sv[2]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001};
    sv[3]  = '{32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101};
    sv[4]  = '{32'h00000000, 32'h7F800000, 32'h7FC00000, 4'b1000};
    sv[5]  = '{32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011};
    sv[6]  = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000};
    sv[7]  = '{32'h7FC00000, 32'h00000000, 32'h7FC00000, 4'b0000};
    sv[8]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000};
    sv[9]  = '{32'h80000000, 32'h40400000, 32'h80000000, 4'b0000};
    sv[10] = '{32'h00000001, 32'h40000000, 32'h00000000, 4'b0000};
    sv[11] = '{32'h3FC00001, 32'h3FC00000, 32'h40100001, 4'b0001};
    sv[12] = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001};
    sv[13] = '{32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'b0001};

    hv[0] = '{32'h4000, 32'h3C00, 32'h4000, 4'b0000};
    hv[1] = '{32'h7BFF, 32'h4000, 32'h7C00, 4'b0101};
    hv[2] = '{32'h3DA8, 32'h3DA8, 32'h4000, 4'b0001};
    hv[3] = '{32'hC000, 32'hC000, 32'h4400, 4'b0000};
    hv[4] = '{32'h0400, 32'h3800, 32'h0000, 4'b0011};
    hv[5] = '{32'h7E00, 32'h3C00, 32'h7E00, 4'b0000};
    hv[6] = '{32'h7D00, 32'h3C00, 32'h7E00, 4'b1000};

    pa[0] = 32'h3F800000; pb[0] = 32'h3F800000; pc[0] = 32'h3F800000;
    pa[1] = 32'h40000000; pb[1] = 32'h40000000; pc[1] = 32'h40800000;
    pa[2] = 32'h40400000; pb[2] = 32'h40400000; pc[2] = 32'h41100000;
    pa[3] = 32'h40000000; pb[3] = 32'h40400000; pc[3] = 32'h40C00000;

    rst_n = 1'b0;
    iv = 1'b0; ordy = 1'b1; a = '0; b = '0;
    hiv = 1'b0; hordy = 1'b1; ha = '0; hb = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", 32'(ov), 32'd0);
    chk("reset c", c, 32'd0);
    chk("reset flags", 32'(fl), 32'd0);
    chk("reset in_ready", 32'(ir), 32'd1);
    chk("reset hp out_valid", 32'(hov), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++)
      run_sp(sv[i], $sformatf("sp%0d", i));
    for (int i = 0; i < 7; i++)
      run_hp(hv[i], $sformatf("hp%0d", i));
    @(posedge clk); #1;
    chk("drained out_valid", 32'(ov), 32'd0);

    // back-to-back issue, one result per cycle
    a = sv[0].a; b = sv[0].b; iv = 1'b1;
    @(posedge clk); #1;
    a = sv[1].a; b = sv[1].b;
    @(posedge clk); #1;
    iv = 1'b0;
    @(posedge clk); #1;
    chk("b2b first valid", 32'(ov), 32'd1);
    chk("b2b first c", c, sv[0].c);
    @(posedge clk); #1;
    chk("b2b second valid", 32'(ov), 32'd1);
    chk("b2b second c", c, sv[1].c);
    @(posedge clk); #1;
    chk("b2b end valid", 32'(ov), 32'd0);

    // backpressure: four offered pairs, pipe holds three
    ordy = 1'b0;
    acc  = 0;
    for (int k = 0; k < 5; k++) begin
      iv = 1'b1;
      a  = pa[acc];
      b  = pb[acc];
      ok = ir;
      @(posedge clk); #1;
      if (ok) acc++;
      if (ov) chk($sformatf("stall c%0d", k), c, pc[0]);
    end
    iv = 1'b0;
    chk("stall accepted", 32'(acc), 32'd3);
    chk("stall in_ready", 32'(ir), 32'd0);
    chk("stall out_valid", 32'(ov), 32'd1);
    ordy = 1'b1;
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("drain%0d valid", j), 32'(ov), 32'd1);
      chk($sformatf("drain%0d c", j), c, pc[j]);
      @(posedge clk); #1;
    end
    chk("drain end valid", 32'(ov), 32'd0);

    // reset while stalled with a full pipe
    ordy = 1'b0;
    iv   = 1'b1;
    for (int j = 0; j < 3; j++) begin
      a = pa[j];
      b = pb[j];
      @(posedge clk); #1;
    end
    iv = 1'b0;
    chk("full out_valid", 32'(ov), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst out_valid", 32'(ov), 32'd0);
    chk("async rst c", c, 32'd0);
    chk("async rst flags", 32'(fl), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ordy  = 1'b1;
    seen  = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(posedge clk); #1;
      if (ov) seen = 1'b1;
    end
    chk("no stale output", 32'(seen), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
